// File: rtl/jericalla_sequencer.sv
// Jericalla sequencer: issues a loadable program of 17-bit words to the
// ROM->ALU->RAM datapath over valid/ready and captures its DS/zf response.
module jericalla_sequencer #(
    parameter int AW = 4,
    parameter int IW = 17,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          halt_on_zero,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic [DW-1:0] ds_in,
    input  logic          zf_in,
    output logic [DW-1:0] result,
    output logic          result_zf,
    output logic          result_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   exec_count,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [AW:0] MAX_CNT = (AW+1)'(2**AW);

    state_t state, state_nxt;

    logic [IW-1:0] mem [2**AW];
    logic [AW:0]   len_q;
    logic          halt_q;
    logic          hs;
    logic          last;
    logic [AW-1:0] pc_nxt;
    logic [IW-1:0] first_word;

    assign instr_valid = (state == ISSUE);
    assign busy        = (state == ISSUE) || (state == CAPTURE);
    assign done        = (state == DONE);

    assign hs     = instr_valid && instr_ready;
    assign pc_nxt = pc + 1'b1;
    assign last   = ({1'b0, pc} == len_q - 1'b1) || (halt_q && zf_in);

    // A write to word 0 in the start cycle must be seen by the run.
    assign first_word = (prog_we && prog_addr == '0) ? prog_data : mem[0];

    // Program storage survives reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (prog_len == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (instr_ready)
                    state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = last ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr        <= '0;
            result       <= '0;
            result_zf    <= 1'b0;
            result_valid <= 1'b0;
            pc           <= '0;
            exec_count   <= '0;
            len_q        <= '0;
            halt_q       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        exec_count <= '0;
                        if (prog_len != '0) begin
                            pc     <= '0;
                            instr  <= first_word;
                            len_q  <= prog_len;
                            halt_q <= halt_on_zero;
                        end
                    end
                end
                ISSUE: begin
                    if (hs && exec_count != MAX_CNT)
                        exec_count <= exec_count + 1'b1;
                end
                CAPTURE: begin
                    result       <= ds_in;
                    result_zf    <= zf_in;
                    result_valid <= 1'b1;
                    if (!last) begin
                        pc    <= pc_nxt;
                        instr <= mem[pc_nxt];
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Scoreboard bench for jericalla_sequencer with a combinational
// stand-in datapath driven from the issued word.
module tb_jericalla_sequencer;

    localparam int AW = 4;
    localparam int IW = 17;
    localparam int DW = 32;
    localparam logic [DW-1:0] DS_MASK = 32'h1357_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          halt_on_zero = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [DW-1:0] ds_in;
    logic          zf_in;
    logic [DW-1:0] result;
    logic          result_zf;
    logic          result_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   exec_count;
    logic          busy;
    logic          done;

    jericalla_sequencer #(.AW(AW), .IW(IW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start), .halt_on_zero(halt_on_zero),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ds_in(ds_in), .zf_in(zf_in),
        .result(result), .result_zf(result_zf), .result_valid(result_valid),
        .pc(pc), .exec_count(exec_count), .busy(busy), .done(done)
    );

    assign ds_in = {15'h0, instr} ^ DS_MASK;
    assign zf_in = (instr == '0);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rv_cnt = 0;
    int exp_exec = 0;
    int exp_pc = 0;
    bit exp_pc_chk = 1'b0;

    logic [IW-1:0] exp_instr_q[$];
    logic [DW:0]   exp_res_q[$];
    logic [IW-1:0] mirror [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready) begin
                if (exp_instr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL issue_unexpected: got %0h expected none", instr);
                end else begin
                    chk("issue_instr", instr, exp_instr_q.pop_front());
                end
            end
            if (result_valid) begin
                rv_cnt++;
                if (exp_res_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL result_unexpected: got %0h expected none", result);
                end else begin
                    chk("result", {result_zf, result}, exp_res_q.pop_front());
                end
            end
        end
    end

    task automatic load(input int addr, input logic [IW-1:0] data);
        @(posedge clk); #1;
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        mirror[addr] = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic kick(input int len, input bit halt, input bit wr,
                        input logic [IW-1:0] wdata, output int t0);
        if (wr) mirror[0] = wdata;
        exp_exec = 0;
        exp_pc_chk = (len != 0);
        for (int i = 0; i < len; i++) begin
            exp_instr_q.push_back(mirror[i]);
            exp_res_q.push_back({mirror[i] == '0, {15'h0, mirror[i]} ^ DS_MASK});
            exp_exec = i + 1;
            exp_pc = i;
            if (halt && mirror[i] == '0) break;
        end
        @(posedge clk); #1;
        prog_len = (AW+1)'(len);
        halt_on_zero = halt;
        start = 1'b1;
        if (wr) begin
            prog_we = 1'b1;
            prog_addr = '0;
            prog_data = wdata;
        end
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic finish(input string tag, input int t0, input int exp_lat);
        bit seen = 1'b0;
        int lat;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done", tag);
            return;
        end
        lat = cyc - t0;
        if (exp_lat >= 0) chk({tag, "_done_latency"}, lat, exp_lat);
        chk({tag, "_exec_count"}, exec_count, exp_exec);
        if (exp_pc_chk) chk({tag, "_pc"}, pc, exp_pc);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_pending"}, exp_instr_q.size() + exp_res_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int rv0;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy_done", {busy, done, result_valid}, 0);
        chk("rst_pc_cnt", {pc, exec_count}, 0);
        chk("rst_result", {result_zf, result}, 0);
        rst_n = 1'b1;

        // Test 1: straight run
        load(0, 17'h06421);
        load(1, 17'h0C221);
        load(2, 17'h00000);
        rv0 = rv_cnt;
        kick(3, 1'b0, 1'b0, '0, t0);
        finish("t1", t0, 7);
        chk("t1_rv_pulses", rv_cnt - rv0, 3);

        // Test 2: backpressure
        instr_ready = 1'b0;
        kick(3, 1'b0, 1'b0, '0, t0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t2_valid_seen", seen, 1);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            chk("t2_hold_valid", instr_valid, 1);
            chk("t2_hold_instr", instr, 17'h06421);
            chk("t2_hold_cnt", exec_count, 0);
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_cnt_once", exec_count, 1);
        finish("t2", t0, -1);

        // Test 3: halt on zero after word 1
        load(1, 17'h00000);
        load(2, 17'h0C221);
        kick(3, 1'b1, 1'b0, '0, t0);
        finish("t3", t0, -1);
        chk("t3_result_zf", result_zf, 1);
        chk("t3_result", result, 32'h1357_0000);

        // Test 4: empty program
        kick(0, 1'b0, 1'b0, '0, t0);
        finish("t4", t0, 1);

        // Test 5: asynchronous reset mid-ISSUE
        kick(3, 1'b0, 1'b0, '0, t0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid && pc == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_reach_pc2", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", instr_valid, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_pc", pc, 0);
        exp_instr_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        kick(3, 1'b0, 1'b0, '0, t0);
        finish("t5", t0, 7);

        // Test 6: writes and start while busy are ignored
        kick(3, 1'b0, 1'b0, '0, t0);
        @(posedge clk); #1;
        prog_we = 1'b1;
        prog_addr = 4'd1;
        prog_data = 17'h1FFFF;
        prog_len = 5'd1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        prog_we = 1'b0;
        start = 1'b0;
        finish("t6", t0, 7);
        kick(3, 1'b0, 1'b0, '0, t0);
        finish("t6b", t0, 7);

        // Test 7: write to word 0 coincident with start
        kick(2, 1'b0, 1'b1, 17'h0AAAA, t0);
        finish("t7", t0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
